// File: rtl/mul_sequencer.sv
// Iterative radix-2 shift-add multiplier (signed/unsigned) with pipeline stall and done strobe.
// Optional MUL_EARLY_TERM_EN: finish RUN as soon as the remaining multiplier bits are zero.
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       ex_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] mcand, product;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic               neg;
  logic               accept, last_iter, is_signed;
  logic [WIDTH-1:0]   a_abs, b_abs;

  assign is_signed = ex_op[0];
  assign accept    = (state == IDLE) && start && ex_op[1] && !flush;
  assign a_abs     = (is_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
  assign b_abs     = (is_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;

`ifdef MUL_EARLY_TERM_EN
  // Stop once no set multiplier bits remain after this edge's shift.
  assign last_iter = (mplier[WIDTH-1:1] == '0) || (count == CW'(WIDTH-1));
`else
  assign last_iter = (count == CW'(WIDTH-1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      mplier    <= '0;
      product   <= '0;
      count     <= '0;
      neg       <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
    end else if (flush) begin
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          mcand   <= {{WIDTH{1'b0}}, a_abs};
          mplier  <= b_abs;
          product <= '0;
          count   <= '0;
          neg     <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
        end
        RUN: begin
`ifdef MUL_EARLY_TERM_EN
          if (mplier != '0) begin
`else
          begin
`endif
            if (mplier[0]) product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
          end
        end
        FIX: {result_hi, result_lo} <= neg ? (~product + 1'b1) : product;
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == RUN) || (state == FIX);
  assign done  = (state == DONE);

endmodule
